// File: rtl/clock_divider_prog.sv
// clock_divider_prog: run-time programmable clock/tick generator.
//
// Divides i_clk by 2*N. The half-period N is loaded through a pending register
// and takes effect only at a period boundary, so o_clk never shows a shortened
// phase. The output is either a 50% square wave or a single-cycle pulse per
// period. Dropping i_enable stops cleanly: a running high phase is allowed to
// finish before the block parks in IDLE.
//
// A period runs low phase first, then high phase. The period boundary is the
// cycle in which o_clk falls. Mode and divide changes are applied there, or
// immediately while IDLE.
//
// Ports:
//   i_clk        system clock, the only clock
//   i_reset      asynchronous reset, active-high
//   i_enable     level: 1 = run, 0 = stop after the current high phase
//   i_mode       0 = square wave, 1 = one-cycle pulse per period
//   i_div_load   one-cycle strobe, captures i_div_value as the pending half-period
//   i_div_value  requested half-period N in i_clk cycles (0 is treated as 1)
//   o_clk        divided output, registered
//   o_tick       one-cycle strobe in the first cycle o_clk reads 1 in each period
//   o_active     1 while the block is not IDLE
//   o_periods    (CLKDIV_PERIOD_CNT_EN only) 16-bit wrapping count of o_tick
//
// Optional feature macro: CLKDIV_PERIOD_CNT_EN adds the o_periods counter.

module clock_divider_prog #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned DIV_DEFAULT = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_mode,
    input  logic                 i_div_load,
    input  logic [CNT_WIDTH-1:0] i_div_value,
    output logic                 o_clk,
    output logic                 o_tick,
    output logic                 o_active
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]          o_periods
`endif
);

    localparam logic [CNT_WIDTH-1:0] HALF_RST =
        (DIV_DEFAULT == 0) ? CNT_WIDTH'(1) : CNT_WIDTH'(DIV_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] half_q, half_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 mode_q, mode_d;
    logic                 phase_q, phase_d;
    logic                 o_clk_q, o_clk_d;
    logic                 tick_q, tick_d;
    logic                 active_q, active_d;

    logic                 boundary;
    logic                 rise;
    logic                 fall;
    logic                 clk_run;
    logic [CNT_WIDTH-1:0] div_clamped;

    // Phase timing of a running divider; phase_q is the internal square wave
    always_comb begin
        boundary    = (cnt_q == (half_q - CNT_WIDTH'(1)));
        rise        = boundary & ~phase_q;
        fall        = boundary & phase_q;
        clk_run     = mode_q ? rise : (phase_q ^ boundary);
        div_clamped = (i_div_value == '0) ? CNT_WIDTH'(1) : i_div_value;
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stay out of IDLE only while a high phase still has to finish
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    state_d = (o_clk_q && clk_run) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end else if (!clk_run) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and outputs
    always_comb begin
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        mode_d       = mode_q;
        o_clk_d      = 1'b0;
        tick_d       = 1'b0;
        active_d     = (state_d != ST_IDLE);

        if (state_q == ST_IDLE) begin
            // Parked: settings are taken over straight away
            cnt_d   = '0;
            phase_d = 1'b0;
            mode_d  = i_mode;
            if (i_div_load) begin
                half_d       = div_clamped;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                half_d       = pend_q;
                pend_valid_d = 1'b0;
            end
        end else begin
            if (state_d == ST_IDLE) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else begin
                cnt_d   = boundary ? '0 : (cnt_q + CNT_WIDTH'(1));
                phase_d = phase_q ^ boundary;
                o_clk_d = clk_run;
                tick_d  = rise;
            end

            // Period boundary: commit latched mode and pending divide
            if (fall) begin
                mode_d = i_mode;
                if (pend_valid_q) begin
                    half_d       = pend_q;
                    pend_valid_d = 1'b0;
                end
            end

            // A load coinciding with a boundary waits for the next one
            if (i_div_load) begin
                pend_d       = div_clamped;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q        <= '0;
            half_q       <= HALF_RST;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            mode_q       <= 1'b0;
            phase_q      <= 1'b0;
            o_clk_q      <= 1'b0;
            tick_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            o_clk_q      <= o_clk_d;
            tick_q       <= tick_d;
            active_q     <= active_d;
        end
    end

    assign o_clk    = o_clk_q;
    assign o_tick   = tick_q;
    assign o_active = active_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] periods_q, periods_d;

    // Counts ticks; holds while IDLE, wraps at 16 bits
    always_comb begin
        periods_d = periods_q;
        if (tick_d) begin
            periods_d = periods_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            periods_q <= 16'd0;
        end else begin
            periods_q <= periods_d;
        end
    end

    assign o_periods = periods_q;
`endif

endmodule
